// File: rtl/wave_pkg.sv
// Shared constants, state encoding and latched-config payload for the RIFF/WAVE recorder.
package wave_pkg;

  localparam int unsigned HDR_LEN       = 44;
  localparam int unsigned RIFF_SIZE_OFS = 4;
  localparam int unsigned DATA_SIZE_OFS = 40;
  localparam int unsigned PATCH_LEN     = 8;
  localparam int unsigned RIFF_SIZE_ADJ = HDR_LEN - 8;

  // FourCC tags stored little-endian so byte n of the tag is word[8n +: 8]
  localparam logic [31:0] FCC_RIFF = 32'h4646_4952;
  localparam logic [31:0] FCC_WAVE = 32'h4556_4157;
  localparam logic [31:0] FCC_FMT  = 32'h2074_6d66;
  localparam logic [31:0] FCC_DATA = 32'h6174_6164;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_CAPTURE,
    ST_PATCH
  } state_e;

  typedef struct packed {
    logic [31:0] rate;
    logic [15:0] max_len;
    logic        bits16;
  } rec_cfg_t;

endpackage

// File: rtl/wave_recorder_if.sv
// Byte-wide sample RAM write port driven by the recorder.
interface wave_recorder_if #(
  parameter int unsigned ADDR_W = 17
);
  logic [ADDR_W-1:0] O_WR_ADDR;
  logic [7:0]        O_WR_DATA;
  logic              O_WR_EN;

  modport master (output O_WR_ADDR, output O_WR_DATA, output O_WR_EN);
  modport slave  (input  O_WR_ADDR, input  O_WR_DATA, input  O_WR_EN);
endinterface

// File: rtl/wave_hdr_gen.sv
// Combinational lookup of canonical 44-byte WAVE header byte at a given index.
module wave_hdr_gen
  import wave_pkg::*;
(
  input  logic [5:0]  idx,
  input  logic [31:0] rate,
  input  logic        bits16,
  output logic [7:0]  hdr_byte_c
);

  logic [31:0] word;

  always_comb begin
    word = '0;
    case (idx[5:2])
      4'd0:    word = FCC_RIFF;
      4'd2:    word = FCC_WAVE;
      4'd3:    word = FCC_FMT;
      4'd4:    word = 32'd16;
      4'd5:    word = 32'h0001_0001;  // format PCM, one channel
      4'd6:    word = rate;
      4'd7:    word = bits16 ? {rate[30:0], 1'b0} : rate;
      4'd8:    word = bits16 ? 32'h0010_0002 : 32'h0008_0001;
      4'd9:    word = FCC_DATA;
      default: word = '0;
    endcase
    hdr_byte_c = word[{idx[1:0], 3'b000} +: 8];
  end

endmodule

// File: rtl/wave_recorder.sv
// Captures a mono PCM stream into RAM as a RIFF/WAVE image, back-patching sizes on stop/full.
module wave_recorder
  import wave_pkg::*;
#(
  parameter int unsigned ADDR_W = 17
) (
  input  logic                I_CLK,
  input  logic                I_RST,
  input  logic                I_START,
  input  logic                I_STOP,
  input  logic [ADDR_W-1:0]   I_BASE_ADDR,
  input  logic [15:0]         I_MAX_LEN,
  input  logic                I_BITS16,
  input  logic [31:0]         I_SAMPLE_RATE,
  input  logic signed [15:0]  I_SND,
  input  logic                I_SND_VALID,
  wave_recorder_if.master     wr,
  output logic                O_BUSY,
  output logic                O_DONE,
  output logic                O_OVERRUN,
  output logic [31:0]         O_DATA_SIZE
);

  state_e            state_q, state_d;
  logic [5:0]        idx_q, idx_d;
  logic              start_q, start_d;
  logic [ADDR_W-1:0] base_q, base_d;
  rec_cfg_t          cfg_q, cfg_d;
  logic [15:0]       count_q, count_d;
  logic              pend_q, pend_d;
  logic [7:0]        hi_q, hi_d;
  logic              stop_q, stop_d;
  logic              ovr_q, ovr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;

  logic              start_edge_c, full_c, patch_wr_c;
  logic [5:0]        hdr_idx_c;
  logic [7:0]        hdr_byte_c, patch_byte_c;
  logic [2:0]        patch_idx_c;
  logic [31:0]       patch_word_c;
  logic [16:0]       need_c;
  logic [ADDR_W-1:0] data_addr_c, patch_addr_c;

  // Write registers are loaded one cycle ahead, so the byte decided now uses the next index
  assign start_edge_c = I_START & ~start_q;
  assign hdr_idx_c    = (state_q == ST_HDR) ? idx_q + 6'd1 : 6'd0;
  assign patch_idx_c  = (state_q == ST_PATCH) ? idx_q[2:0] + 3'd1 : 3'd0;
  assign need_c       = 17'(count_q) + (cfg_q.bits16 ? 17'd2 : 17'd1);
  assign full_c       = need_c > 17'(cfg_q.max_len);
  assign data_addr_c  = base_q + ADDR_W'(HDR_LEN) + ADDR_W'(count_q);
  assign patch_word_c = patch_idx_c[2] ? 32'(count_q) : 32'(count_q) + 32'(RIFF_SIZE_ADJ);
  assign patch_addr_c = base_q + (patch_idx_c[2] ? ADDR_W'(DATA_SIZE_OFS) : ADDR_W'(RIFF_SIZE_OFS))
                      + ADDR_W'(patch_idx_c[1:0]);
  assign patch_byte_c = patch_word_c[{patch_idx_c[1:0], 3'b000} +: 8];

  wave_hdr_gen u_hdr (
    .idx        (hdr_idx_c),
    .rate       (cfg_q.rate),
    .bits16     (cfg_q.bits16),
    .hdr_byte_c (hdr_byte_c)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    start_d    = I_START;
    base_d     = base_q;
    cfg_d      = cfg_q;
    count_d    = count_q;
    pend_d     = pend_q;
    hi_d       = hi_q;
    stop_d     = stop_q;
    ovr_d      = ovr_q;
    done_d     = 1'b0;
    wr_en_d    = 1'b0;
    wr_addr_d  = '0;
    wr_data_d  = '0;
    patch_wr_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_edge_c) begin
          base_d    = I_BASE_ADDR;
          cfg_d     = '{rate: I_SAMPLE_RATE, max_len: I_MAX_LEN, bits16: I_BITS16};
          count_d   = '0;
          ovr_d     = 1'b0;
          stop_d    = 1'b0;
          pend_d    = 1'b0;
          idx_d     = '0;
          state_d   = ST_HDR;
          wr_en_d   = 1'b1;
          wr_addr_d = I_BASE_ADDR;
          wr_data_d = hdr_byte_c;
        end
      end
      ST_HDR: begin
        if (idx_q == 6'(HDR_LEN - 1)) begin
          state_d = ST_CAPTURE;
        end else begin
          idx_d     = idx_q + 6'd1;
          wr_en_d   = 1'b1;
          wr_addr_d = base_q + ADDR_W'(hdr_idx_c);
          wr_data_d = hdr_byte_c;
        end
      end
      ST_CAPTURE: begin
        if (I_STOP) stop_d = 1'b1;
        if (pend_q) begin
          pend_d    = 1'b0;
          wr_en_d   = 1'b1;
          wr_addr_d = data_addr_c;
          wr_data_d = hi_q;
          count_d   = count_q + 16'd1;
          if (I_SND_VALID) ovr_d = 1'b1;
        end else if (I_STOP || stop_q || full_c) begin
          // Stop has priority over a coincident strobe; full never flags overrun
          state_d    = ST_PATCH;
          idx_d      = '0;
          patch_wr_c = 1'b1;
        end else if (I_SND_VALID) begin
          wr_en_d   = 1'b1;
          wr_addr_d = data_addr_c;
          count_d   = count_q + 16'd1;
          if (cfg_q.bits16) begin
            wr_data_d = I_SND[7:0];
            hi_d      = I_SND[15:8];
            pend_d    = 1'b1;
          end else begin
            wr_data_d = I_SND[15:8] ^ 8'h80;
          end
        end
      end
      ST_PATCH: begin
        if (idx_q == 6'(PATCH_LEN - 1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          idx_d      = idx_q + 6'd1;
          patch_wr_c = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (patch_wr_c) begin
      wr_en_d   = 1'b1;
      wr_addr_d = patch_addr_c;
      wr_data_d = patch_byte_c;
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      start_q   <= 1'b0;
      base_q    <= '0;
      cfg_q     <= '0;
      count_q   <= '0;
      pend_q    <= 1'b0;
      hi_q      <= '0;
      stop_q    <= 1'b0;
      ovr_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      start_q   <= start_d;
      base_q    <= base_d;
      cfg_q     <= cfg_d;
      count_q   <= count_d;
      pend_q    <= pend_d;
      hi_q      <= hi_d;
      stop_q    <= stop_d;
      ovr_q     <= ovr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr.O_WR_EN   = wr_en_q;
  assign wr.O_WR_ADDR = wr_addr_q;
  assign wr.O_WR_DATA = wr_data_q;
  assign O_BUSY       = busy_q;
  assign O_DONE       = done_q;
  assign O_OVERRUN    = ovr_q;
  assign O_DATA_SIZE  = 32'(count_q);

endmodule

// File: tb/tb_wave_recorder.sv
// Directed bench for wave_recorder: header content, sample packing, capacity, overrun, stop and reset.
module tb_wave_recorder;
  import wave_pkg::*;

  localparam int unsigned ADDR_W = 17;

  logic               clk = 1'b0;
  logic               rst, start, stop, bits16, snd_valid;
  logic [ADDR_W-1:0]  base;
  logic [15:0]        max_len;
  logic [31:0]        rate;
  logic signed [15:0] snd;
  logic               busy, done, overrun;
  logic [31:0]        data_size;

  bit [7:0] mem [0:(1<<ADDR_W)-1];
  int       done_cnt = 0;
  int       errors = 0;
  int       checks = 0;
  int       n, d0;

  wave_recorder_if #(.ADDR_W(ADDR_W)) wr_if ();

  wave_recorder #(.ADDR_W(ADDR_W)) dut (
    .I_CLK         (clk),
    .I_RST         (rst),
    .I_START       (start),
    .I_STOP        (stop),
    .I_BASE_ADDR   (base),
    .I_MAX_LEN     (max_len),
    .I_BITS16      (bits16),
    .I_SAMPLE_RATE (rate),
    .I_SND         (snd),
    .I_SND_VALID   (snd_valid),
    .wr            (wr_if),
    .O_BUSY        (busy),
    .O_DONE        (done),
    .O_OVERRUN     (overrun),
    .O_DATA_SIZE   (data_size)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_if.O_WR_EN) mem[wr_if.O_WR_ADDR] <= wr_if.O_WR_DATA;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd32(input logic [ADDR_W-1:0] a);
    return {mem[ADDR_W'(a + 17'd3)], mem[ADDR_W'(a + 17'd2)], mem[ADDR_W'(a + 17'd1)], mem[a]};
  endfunction

  task automatic start_rec(input logic [ADDR_W-1:0] b, input logic [15:0] ml,
                           input logic b16, input logic [31:0] r);
    base = b; max_len = ml; bits16 = b16; rate = r;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic strobe(input logic [15:0] v);
    snd = v; snd_valid = 1'b1;
    step();
    snd_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 60) begin
      step();
      cyc++;
    end
    chk("done_seen", 32'(done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; bits16 = 1'b0; snd_valid = 1'b0;
    base = '0; max_len = '0; rate = '0; snd = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_wr_en", 32'(wr_if.O_WR_EN), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_size", data_size, 32'd0);

    // 8-bit recording
    d0 = done_cnt;
    start_rec(17'h100, 16'd1000, 1'b0, 32'd8000);
    chk("t1_busy_k1", 32'(busy), 32'd1);
    chk("t1_hdr0_addr", 32'(wr_if.O_WR_ADDR), 32'h100);
    chk("t1_hdr0_data", 32'(wr_if.O_WR_DATA), 32'h52);
    repeat (44) step();
    strobe(16'h1234);
    chk("t1_s0_addr", 32'(wr_if.O_WR_ADDR), 32'h12C);
    chk("t1_s0_data", 32'(wr_if.O_WR_DATA), 32'h92);
    chk("t1_s0_size", data_size, 32'd1);
    strobe(16'h8000);
    strobe(16'h7FFF);
    stop = 1'b1;
    step();
    stop = 1'b0;
    wait_done(n);
    chk("t1_patch_latency", 32'(n), 32'd8);
    chk("t1_busy_at_done", 32'(busy), 32'd0);
    chk("t1_size", data_size, 32'd3);
    chk("t1_riff_tag", rd32(17'h100), 32'h4646_4952);
    chk("t1_riff_size", rd32(17'h104), 32'h27);
    chk("t1_data_size", rd32(17'h128), 32'd3);
    chk("t1_d0", 32'(mem[17'h12C]), 32'h92);
    chk("t1_d1", 32'(mem[17'h12D]), 32'h00);
    chk("t1_d2", 32'(mem[17'h12E]), 32'hFF);
    repeat (3) step();
    chk("t1_done_once", 32'(done_cnt - d0), 32'd1);

    // 16-bit header, sample packing, stop during pending high byte
    start_rec(17'h0, 16'd1000, 1'b1, 32'd44100);
    repeat (44) step();
    strobe(16'hABCD);
    chk("t2_lo_addr", 32'(wr_if.O_WR_ADDR), 32'd44);
    chk("t2_lo_data", 32'(wr_if.O_WR_DATA), 32'hCD);
    stop = 1'b1;
    step();
    chk("t2_hi_addr", 32'(wr_if.O_WR_ADDR), 32'd45);
    chk("t2_hi_data", 32'(wr_if.O_WR_DATA), 32'hAB);
    stop = 1'b0;
    step();
    chk("t2_patch0_addr", 32'(wr_if.O_WR_ADDR), 32'd4);
    chk("t2_patch0_data", 32'(wr_if.O_WR_DATA), 32'h26);
    wait_done(n);
    chk("t2_patch_latency", 32'(n), 32'd8);
    chk("t2_rate", rd32(17'd24), 32'h0000_AC44);
    chk("t2_byte_rate", rd32(17'd28), 32'h0001_5888);
    chk("t2_align", 32'(mem[17'd32]), 32'd2);
    chk("t2_bits", 32'(mem[17'd34]), 32'd16);
    chk("t2_data_tag", rd32(17'd36), 32'h6174_6164);
    chk("t2_data_size", rd32(17'd40), 32'd2);

    // Capacity: max 5 bytes in 16-bit mode holds two samples
    start_rec(17'h200, 16'd5, 1'b1, 32'd16000);
    repeat (44) step();
    for (int i = 0; i < 60; i++) begin
      snd = 16'(16'h1111 * (i / 4 + 1));
      snd_valid = (i % 4 == 0);
      step();
      if (done) break;
    end
    snd_valid = 1'b0;
    chk("t3_done_seen", 32'(done), 32'd1);
    chk("t3_size", data_size, 32'd4);
    chk("t3_overrun", 32'(overrun), 32'd0);
    chk("t3_data_size", rd32(17'h228), 32'd4);
    chk("t3_riff_size", rd32(17'h204), 32'd40);
    chk("t3_samples", rd32(17'h22C), 32'h2222_1111);
    chk("t3_no_third", {16'd0, mem[17'h231], mem[17'h230]}, 32'd0);

    // Overrun, then stop and strobe in the same cycle
    start_rec(17'h400, 16'd1000, 1'b1, 32'd22050);
    repeat (44) step();
    strobe(16'h1357);
    strobe(16'h2468);
    chk("t4_hi_data", 32'(wr_if.O_WR_DATA), 32'h13);
    chk("t4_overrun", 32'(overrun), 32'd1);
    chk("t4_size", data_size, 32'd2);
    step();
    chk("t4_drop_no_wr", 32'(wr_if.O_WR_EN), 32'd0);
    snd = 16'h7777; snd_valid = 1'b1; stop = 1'b1;
    step();
    snd_valid = 1'b0; stop = 1'b0;
    wait_done(n);
    chk("t4_stop_latency", 32'(n), 32'd8);
    chk("t4_final_size", data_size, 32'd2);
    chk("t4_sample", {16'd0, mem[17'h42D], mem[17'h42C]}, 32'h1357);
    chk("t4_discarded", 32'(mem[17'h42E]), 32'd0);
    chk("t4_overrun_sticky", 32'(overrun), 32'd1);

    // Reset during header, then a clean recording
    start_rec(17'h600, 16'd100, 1'b0, 32'd8000);
    chk("t5_overrun_cleared", 32'(overrun), 32'd0);
    repeat (10) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_rst_wr_en", 32'(wr_if.O_WR_EN), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_size", data_size, 32'd0);
    d0 = done_cnt;
    repeat (50) step();
    chk("t5_no_done", 32'(done_cnt - d0), 32'd0);
    start_rec(17'h600, 16'd100, 1'b0, 32'd8000);
    chk("t5_busy", 32'(busy), 32'd1);
    repeat (44) step();
    strobe(16'h00FF);
    stop = 1'b1;
    step();
    stop = 1'b0;
    wait_done(n);
    chk("t5_sample", 32'(mem[17'h62C]), 32'h80);
    chk("t5_data_size", rd32(17'h628), 32'd1);
    chk("t5_riff_size", rd32(17'h604), 32'd37);
    chk("t5_wave_tag", rd32(17'h608), 32'h4556_4157);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wave_recorder.md
# wave_recorder

Records a mono PCM stream into a byte-wide sample RAM as a complete, playable RIFF/WAVE image: 44-byte canonical header followed by sample data. Sits beside the sound mixer and captures `I_SND` on a sample strobe. On stop or when full, it back-patches the two size fields so the image can be handed straight to the wave player.

## Interface
- `ADDR_W`, 17: RAM byte-address width.

- `I_CLK` in 1: system clock.
- `I_RST` in 1: synchronous reset, active-high.
- `I_START` in 1: start request. Rising edge, detected against a registered copy, begins a recording. Ignored while `O_BUSY`.
- `I_STOP` in 1: level. Ends capture; see Operation.
- `I_BASE_ADDR` in `ADDR_W`: RAM address of header byte 0. Latched on start.
- `I_MAX_LEN` in 16: data-chunk capacity in bytes, excluding the header. Latched on start.
- `I_BITS16` in 1: 1 selects 16-bit signed little-endian; 0 selects 8-bit unsigned. Latched on start.
- `I_SAMPLE_RATE` in 32: sample rate in Hz, written to the header. Latched on start.
- `I_SND` in 16 (signed): sample value.
- `I_SND_VALID` in 1: one-cycle sample strobe.
- `O_WR_ADDR` out `ADDR_W`: RAM write address.
- `O_WR_DATA` out 8: RAM write data.
- `O_WR_EN` out 1: RAM write strobe. At most one byte is written per cycle.
- `O_BUSY` out 1: high from the cycle after the start edge until `O_DONE`.
- `O_DONE` out 1: one-cycle pulse when the image is complete.
- `O_OVERRUN` out 1: sticky. Set when a strobe is dropped; cleared on the next start.
- `O_DATA_SIZE` out 32: current data-chunk byte count. Holds its final value after done.

## Operation
- States: IDLE → HDR → CAPTURE → PATCH → IDLE.
- IDLE
  - Outputs low and count holds.
  - A start edge latches the config, clears the count and `O_OVERRUN`, sets index 0, and goes to HDR.
- HDR: writes header bytes 0..43 to `base+i`, one per cycle, in order:
  - `"RIFF"`, then 4 size bytes written as 0.
  - `"WAVE"`, `"fmt "`.
  - 16 (32-bit LE).
  - 1 (PCM, 16-bit).
  - 1 channel (16-bit).
  - Sample rate (32-bit LE).
  - Byte rate = rate×B (32-bit LE).
  - Block align = B (16-bit).
  - Bits = 8·B (16-bit).
  - `"data"`, then 4 size bytes written as 0.
  - B = 2 when `I_BITS16`, else 1. Byte rate is computed as a shift, not a multiply.
  - Strobes arriving during HDR are ignored and do not set overrun.
- CAPTURE: a strobe is accepted when no byte is pending and `count + B <= max_len`.
  - 16-bit accepted sample: low byte written to `base+44+count` the next cycle, high byte the cycle after; count += 2.
  - 8-bit accepted sample: byte `I_SND[15:8] ^ 8'h80` written the next cycle; count += 1.
  - A strobe arriving while a byte is pending is dropped and sets `O_OVERRUN`.
  - When `count + B > max_len`, the block leaves for PATCH without accepting the sample. No overrun is flagged. Result: 16-bit images always have even size.
  - `I_STOP` high: any pending byte finishes first, then the block goes to PATCH.
  - `I_STOP` and a strobe in the same cycle: stop wins and the sample is not accepted.
- PATCH: 8 writes.
  - Offsets 4..7 receive `count+36` LE.
  - Offsets 40..43 receive `count` LE.
  - Then `O_DONE` pulses for one cycle, `O_BUSY` drops, and the state returns to IDLE.
- Address arithmetic is modulo 2^`ADDR_W`. Wrap past the top of the RAM is not checked; the caller sizes `max_len`.
- Size arithmetic is 32-bit; count fits in 16 bits.

## Timing
- Reset: in the cycle after `I_RST` is high, the state is IDLE and all outputs are 0, including `O_DATA_SIZE` and `O_OVERRUN`. Start-edge history is cleared.
- Reset mid-recording aborts with no patching; the RAM holds a partial image.
- Start edge in cycle k:
  - Header writes occur in cycles k+1..k+44.
  - CAPTURE begins at k+45.
  - `O_BUSY` is high from k+1.
- Sample latency: strobe in cycle s → first byte in s+1; 16-bit high byte in s+2.
  - Minimum strobe spacing is 2 cycles for 16-bit and 1 cycle for 8-bit.
- Stop or full detected in cycle t with nothing pending → patch writes in t+1..t+8, `O_DONE` at t+9.
  - If a high byte is pending, the sequence shifts by one cycle.
- `O_DATA_SIZE` updates in the same cycle as the write that advances the count.

## Structure
- Package `wave_pkg` holds:
  - Header offset constants: `RIFF_SIZE_OFS` = 4, `DATA_SIZE_OFS` = 40, `HDR_LEN` = 44.
  - FourCC byte constants.
  - The state enum.
- Sub-module `wave_hdr_gen`: combinational. Inputs are the 6-bit index, rate and bits16; output is the header byte. The FSM, counters and write mux stay in `wave_recorder`.

## Test plan
- 8-bit recording:
  - Stimulus: base 0x100, rate 8000, `I_BITS16`=0, max 1000; 3 strobes of 0x1234, 0x8000 and 0x7FFF, then stop.
  - Data at 0x12C..0x12E = 0x92, 0x00, 0xFF.
  - Bytes 0x104..0x107 = 0x27,0,0,0; bytes 0x128..0x12B = 3,0,0,0.
  - `O_DONE` pulses once.
- 16-bit header:
  - Stimulus: rate 44100, `I_BITS16`=1.
  - Bytes 24..27 = 44 AC 00 00; 28..31 = 88 58 01 00; 32 = 2; 34 = 16.
  - A sample of 0xABCD writes CD at 44 and AB at 45.
- Capacity: `I_BITS16`=1, max 5; strobes every 4 cycles.
  - Exactly 2 samples are stored and size = 4.
  - PATCH starts automatically and `O_OVERRUN` = 0.
- Overrun: 16-bit with strobes in consecutive cycles.
  - The second strobe is dropped, `O_OVERRUN`=1, and count advances by 2 only.
- Stop and strobe in the same cycle: the sample is discarded.
  - Stop arriving during a pending high byte: the high byte is written before the first patch write.
- `I_RST` in HDR cycle 10: next cycle `O_WR_EN`=0, `O_BUSY`=0, and no `O_DONE`. A new start then records normally.
